// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, frame
// constants, the snapshot record and the frame byte helpers.
package uart_sched_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam logic [7:0] FRAME_HDR  = 8'h54;
    localparam logic [7:0] FRAME_TERM = 8'h0A;
    localparam int         FRAME_LEN  = 13;
    localparam logic [3:0] LAST_IDX   = 4'(FRAME_LEN - 1);

    typedef struct packed {
        logic [15:0] solar;
        logic [63:0] thr;
        logic [7:0]  csum;
    } frame_snap_t;

    function automatic logic [7:0] payload_xor(input logic [15:0] solar,
                                               input logic [63:0] thr);
        logic [7:0] x;
        x = solar[15:8] ^ solar[7:0];
        for (int i = 0; i < 8; i++) begin
            x = x ^ thr[8*i +: 8];
        end
        return x;
    endfunction

    // Byte at position idx of the frame built from a captured snapshot.
    function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                              input frame_snap_t s);
        logic [7:0] b;
        case (idx)
            4'd0:    b = FRAME_HDR;
            4'd1:    b = s.solar[15:8];
            4'd2:    b = s.solar[7:0];
            4'd3:    b = s.thr[7:0];
            4'd4:    b = s.thr[15:8];
            4'd5:    b = s.thr[23:16];
            4'd6:    b = s.thr[31:24];
            4'd7:    b = s.thr[39:32];
            4'd8:    b = s.thr[47:40];
            4'd9:    b = s.thr[55:48];
            4'd10:   b = s.thr[63:56];
            4'd11:   b = s.csum;
            4'd12:   b = FRAME_TERM;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_timer.sv
// Free-running report period counter; tick marks the wrap from PERIOD-1 to 0.
module report_timer #(
    parameter int PERIOD = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int         W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Disabling the timer parks it at zero so a re-enable restarts a full period.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates one UART transmitter between single echo bytes and 13-byte
// threshold report frames, which are sent atomically from a snapshot.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int REPORT_PERIOD = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        echo_valid,
    input  logic [7:0]  echo_data,
    output logic        echo_ready,
    input  logic        report_req,
    input  logic        auto_en,
    input  logic [15:0] solar_th,
    input  logic [63:0] thr_bytes,
    input  logic        idle_ready_tx,
    output logic        start_tx,
    output logic [7:0]  data_tx,
    output logic        report_busy,
    output logic        report_done
);

    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        pend_q, pend_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  echo_byte_q, echo_byte_d;
    frame_snap_t snap_q, snap_d;
    logic        period_tick;

    report_timer #(
        .PERIOD(REPORT_PERIOD)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (auto_en),
        .tick(period_tick)
    );

    // busy_q doubles as the "frame in progress" flag, so echoes are locked
    // out from the first frame strobe until the terminator has gone out.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_d      = pend_q | report_req | period_tick;
        busy_d      = busy_q;
        done_d      = 1'b0;
        echo_byte_d = echo_byte_q;
        snap_d      = snap_q;

        case (state_q)
            ST_IDLE: begin
                if (idle_ready_tx && !busy_q) begin
                    if (echo_valid) begin
                        echo_byte_d = echo_data;
                        state_d     = ST_SEND;
                    end else if (pend_q) begin
                        snap_d.solar = solar_th;
                        snap_d.thr   = thr_bytes;
                        snap_d.csum  = payload_xor(solar_th, thr_bytes);
                        idx_d        = 4'd0;
                        busy_d       = 1'b1;
                        pend_d       = report_req | period_tick;
                        state_d      = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (idle_ready_tx) begin
                    if (busy_q && (idx_q != LAST_IDX)) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_SEND;
                    end else if (busy_q) begin
                        idx_d   = 4'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            echo_byte_q <= 8'h00;
            snap_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            echo_byte_q <= echo_byte_d;
            snap_q      <= snap_d;
        end
    end

    assign echo_ready  = !rst && (state_q == ST_IDLE) && idle_ready_tx &&
                         !busy_q && echo_valid;
    assign start_tx    = !rst && (state_q == ST_SEND);
    assign data_tx     = start_tx ? (busy_q ? frame_byte(idx_q, snap_q) : echo_byte_q)
                                  : 8'h00;
    assign report_busy = busy_q;
    assign report_done = done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler: a table of echo/frame
// vectors plus hand-written sequences for the multi-cycle corner cases.
module tb_uart_tx_scheduler;

    localparam int PERIOD = 100;

    logic        clk;
    logic        rst;
    logic        echo_valid;
    logic [7:0]  echo_data;
    logic        echo_ready;
    logic        report_req;
    logic        auto_en;
    logic [15:0] solar_th;
    logic [63:0] thr_bytes;
    logic        idle_ready_tx;
    logic        start_tx;
    logic [7:0]  data_tx;
    logic        report_busy;
    logic        report_done;

    logic        uart_idle;
    logic        uartHold;

    logic [7:0]  cap[$];
    int          strobe_cyc[$];
    int          done_cnt;
    int          ready_cnt;
    int          cyc;
    int          tests;
    int          failures;

    typedef struct {
        bit          isEcho;
        logic [7:0]  echoByte;
        logic [15:0] solar;
        logic [63:0] thr;
        logic [7:0]  csum;
    } vec_t;

    vec_t vecs[8];

    uart_tx_scheduler #(
        .REPORT_PERIOD(PERIOD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .echo_valid   (echo_valid),
        .echo_data    (echo_data),
        .echo_ready   (echo_ready),
        .report_req   (report_req),
        .auto_en      (auto_en),
        .solar_th     (solar_th),
        .thr_bytes    (thr_bytes),
        .idle_ready_tx(idle_ready_tx),
        .start_tx     (start_tx),
        .data_tx      (data_tx),
        .report_busy  (report_busy),
        .report_done  (report_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // UART model: busy from the edge after each strobe for three cycles.
    initial begin
        uart_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (start_tx === 1'b1) begin
                @(posedge clk);
                #1 uart_idle = 1'b0;
                repeat (3) @(posedge clk);
                #1 uart_idle = 1'b1;
            end
        end
    end

    assign idle_ready_tx = uart_idle & ~uartHold;

    initial begin
        forever begin
            @(negedge clk);
            if (start_tx === 1'b1) begin
                cap.push_back(data_tx);
                strobe_cyc.push_back(cyc);
            end
            if (report_done === 1'b1) done_cnt = done_cnt + 1;
            if (echo_ready === 1'b1) ready_cnt = ready_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests = tests + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearMon();
        cap.delete();
        strobe_cyc.delete();
        done_cnt  = 0;
        ready_cnt = 0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind 0: strobes captured, 1: report_done pulses, 2: echo accepts
    task automatic waitUntil(input int kind, input int n, input int budget,
                             input string name);
        int i;
        int v;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            v = (kind == 0) ? cap.size() : ((kind == 1) ? done_cnt : ready_cnt);
            if (v >= n) break;
        end
        #1;
        if (i == budget) begin
            tests    = tests + 1;
            failures = failures + 1;
            $display("[TB] FAIL %s: timeout after %0d cycles", name, budget);
        end
    endtask

    task automatic pulseReq();
        report_req = 1'b1;
        @(posedge clk);
        #1 report_req = 1'b0;
    endtask

    function automatic logic [7:0] expByte(input vec_t v, input int i);
        logic [7:0] b;
        case (i)
            0:       b = 8'h54;
            1:       b = v.solar[15:8];
            2:       b = v.solar[7:0];
            11:      b = v.csum;
            12:      b = 8'h0A;
            default: b = v.thr[8*(i-3) +: 8];
        endcase
        return b;
    endfunction

    task automatic applyStimulus(input vec_t v, input int k);
        clearMon();
        solar_th  = v.solar;
        thr_bytes = v.thr;
        if (v.isEcho) begin
            echo_data  = v.echoByte;
            echo_valid = 1'b1;
            waitUntil(2, 1, 50, $sformatf("vec%0d_accept", k));
            echo_valid = 1'b0;
            idleCycles(20);
            checkOutput($sformatf("vec%0d_count", k), cap.size(), 1);
            checkOutput($sformatf("vec%0d_byte", k), cap[0], v.echoByte);
            checkOutput($sformatf("vec%0d_ready_cycles", k), ready_cnt, 1);
        end else begin
            pulseReq();
            waitUntil(1, 1, 400, $sformatf("vec%0d_done", k));
            idleCycles(10);
            checkOutput($sformatf("vec%0d_count", k), cap.size(), 13);
            for (int i = 0; i < 13; i++) begin
                checkOutput($sformatf("vec%0d_byte%0d", k, i), cap[i], expByte(v, i));
            end
            checkOutput($sformatf("vec%0d_done_pulses", k), done_cnt, 1);
            checkOutput($sformatf("vec%0d_busy_after", k), report_busy, 0);
        end
    endtask

    initial begin
        int n;
        int base;
        tests      = 0;
        failures   = 0;
        done_cnt   = 0;
        ready_cnt  = 0;
        uartHold   = 1'b0;
        rst        = 1'b1;
        echo_valid = 1'b1;
        echo_data  = 8'h55;
        report_req = 1'b0;
        auto_en    = 1'b0;
        solar_th   = 16'h0000;
        thr_bytes  = 64'h0;

        vecs[0] = '{1'b0, 8'h00, 16'h09F6, 64'h1023102310231023, 8'hFF};
        vecs[1] = '{1'b1, 8'h77, 16'h0000, 64'h0, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 16'h0000, 64'h0, 8'h00};
        vecs[3] = '{1'b0, 8'h00, 16'h1234, 64'h0000000000000001, 8'h27};
        vecs[4] = '{1'b1, 8'h00, 16'h0000, 64'h0, 8'h00};
        vecs[5] = '{1'b0, 8'h00, 16'hFFFF, 64'h8040201008040201, 8'hFF};
        vecs[6] = '{1'b0, 8'h00, 16'hA55A, 64'h00000000000000F0, 8'h0F};
        vecs[7] = '{1'b1, 8'hFF, 16'h0000, 64'h0, 8'h00};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_start_tx", start_tx, 0);
        checkOutput("rst_data_tx", data_tx, 0);
        checkOutput("rst_echo_ready", echo_ready, 0);
        checkOutput("rst_report_busy", report_busy, 0);
        checkOutput("rst_report_done", report_done, 0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        echo_valid = 1'b0;
        idleCycles(5);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k], k);
        end

        // Echo raised mid-frame must wait for the terminator.
        clearMon();
        solar_th  = vecs[0].solar;
        thr_bytes = vecs[0].thr;
        pulseReq();
        waitUntil(0, 5, 100, "atomic_byte4");
        echo_data  = 8'h3C;
        echo_valid = 1'b1;
        waitUntil(2, 1, 300, "atomic_accept");
        echo_valid = 1'b0;
        n = cap.size();
        idleCycles(20);
        checkOutput("atomic_ready_after_frame", n, 13);
        checkOutput("atomic_count", cap.size(), 14);
        checkOutput("atomic_term", cap[12], 8'h0A);
        checkOutput("atomic_echo", cap[13], 8'h3C);
        checkOutput("atomic_ready_cycles", ready_cnt, 1);
        checkOutput("atomic_done", done_cnt, 1);

        // Echo and report both pending while the UART is busy: echo goes first.
        clearMon();
        uartHold  = 1'b1;
        solar_th  = 16'h1234;
        thr_bytes = 64'h0000000000000001;
        pulseReq();
        echo_data  = 8'hA5;
        echo_valid = 1'b1;
        idleCycles(20);
        checkOutput("hold_no_strobe", cap.size(), 0);
        checkOutput("hold_no_ready", ready_cnt, 0);
        uartHold = 1'b0;
        waitUntil(2, 1, 10, "hold_accept");
        echo_valid = 1'b0;
        waitUntil(1, 1, 400, "hold_done");
        idleCycles(10);
        checkOutput("hold_count", cap.size(), 14);
        checkOutput("hold_echo_first", cap[0], 8'hA5);
        checkOutput("hold_hdr", cap[1], 8'h54);
        checkOutput("hold_solar_lo", cap[3], 8'h34);
        checkOutput("hold_csum", cap[12], 8'h27);

        // Snapshot holds through the frame; three requests collapse to one frame.
        clearMon();
        solar_th  = 16'h1111;
        thr_bytes = 64'h0000000000000001;
        pulseReq();
        waitUntil(0, 3, 100, "snap_byte2");
        checkOutput("snap_busy_mid", report_busy, 1);
        solar_th  = 16'h2222;
        thr_bytes = 64'h0000000000000005;
        for (int i = 0; i < 3; i++) begin
            pulseReq();
            idleCycles(5);
        end
        waitUntil(1, 2, 600, "snap_done2");
        idleCycles(100);
        checkOutput("snap_count", cap.size(), 26);
        checkOutput("snap_done", done_cnt, 2);
        checkOutput("snap_f1_solar_hi", cap[1], 8'h11);
        checkOutput("snap_f1_thr0", cap[3], 8'h01);
        checkOutput("snap_f1_csum", cap[11], 8'h01);
        checkOutput("snap_f2_solar_hi", cap[14], 8'h22);
        checkOutput("snap_f2_thr0", cap[16], 8'h05);
        checkOutput("snap_f2_csum", cap[24], 8'h05);

        // Reset after byte 5 aborts the frame; the next report restarts at byte 0.
        clearMon();
        solar_th  = vecs[0].solar;
        thr_bytes = vecs[0].thr;
        pulseReq();
        waitUntil(0, 6, 100, "abort_byte5");
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_start_tx", start_tx, 0);
        checkOutput("abort_busy", report_busy, 0);
        checkOutput("abort_done_out", report_done, 0);
        checkOutput("abort_data_tx", data_tx, 0);
        idleCycles(40);
        checkOutput("abort_count", cap.size(), 6);
        checkOutput("abort_no_done", done_cnt, 0);
        pulseReq();
        waitUntil(1, 1, 400, "abort_next_done");
        idleCycles(10);
        checkOutput("abort_next_count", cap.size(), 19);
        checkOutput("abort_next_hdr", cap[6], 8'h54);
        checkOutput("abort_next_term", cap[18], 8'h0A);

        // Periodic reports: terminal count in cycle 99, decision in 100, strobe in 101.
        clearMon();
        auto_en = 1'b1;
        base    = cyc;
        waitUntil(1, 2, 400, "periodic_done2");
        auto_en = 1'b0;
        idleCycles(5);
        checkOutput("periodic_count", cap.size(), 26);
        checkOutput("periodic_first", strobe_cyc[0] - base, 101);
        checkOutput("periodic_second", strobe_cyc[13] - base, 201);
        checkOutput("periodic_hdr", cap[13], 8'h54);
        idleCycles(300);
        checkOutput("periodic_off_count", cap.size(), 26);
        checkOutput("periodic_off_done", done_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
